vga_vram_arbiter: RTL and testbench
===================================

VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 Parameters SHALL be: FB_W, default 160, framebuffer width in pixels; FB_H, default 120, framebuffer height; FB_SIZE, default 19200, FB_W*FB_H.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  pixel clock, 25 MHz, single clock domain.
- clr  in  1  reset, asynchronous, active-low.
- px_x  in  10  active-area column, 0..639.
- px_y  in  10  active-area row, 0..479.
- vidon  in  1  active-video flag.
- hsync_in, vsync_in  in  1 each  raw syncs from the timing generator.
- hsync, vsync  out  1 each  syncs delayed to align with RGB.
- red, green  out  3 each  pixel colour.
- blue  out  2  pixel colour.
- wr_req  in  1  host write request, level.
- wr_addr  in  15  host write address.
- wr_data  in  8  host write data, RGB332.
- wr_ack  out  1  host write accepted.
- fill_start  in  1  one-cycle pulse; starts a framebuffer fill.
- fill_color  in  8  fill value.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when the fill completes.
- ram_addr  out  15  VRAM address.
- ram_we  out  1  VRAM write enable.
- ram_wdata  out  8  VRAM write data.
- ram_rdata  in  8  VRAM synchronous read data, valid one clk after the address.

Function
REQ-003 A display slot SHALL exist in each cycle with vidon=1 and px_x[1:0]=0. In that slot: ram_addr = px_y[8:2]*160 + px_x[9:2], computed as (y<<7)+(y<<5)+x, and ram_we=0.
REQ-004 Slot priority SHALL be display > fill > host write. The port is granted to at most one requester per cycle.
REQ-005 ram_addr, ram_we and ram_wdata SHALL be combinational from the current grant. With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
REQ-006 Host write grant conditions: wr_req=1, not a display slot, and fill FSM in IDLE. On grant: wr_ack=1 in the same cycle, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
REQ-007 Out-of-range host write (wr_addr >= FB_SIZE) SHALL be acknowledged as in REQ-006 but with ram_we=0.
REQ-008 The host SHALL hold wr_addr and wr_data stable while wr_req=1 and wr_ack=0. Back-to-back acks on consecutive cycles are permitted.
REQ-009 Fill FSM states SHALL be IDLE and FILL.
- IDLE to FILL on fill_start=1; fill_cnt cleared to 0; fill_color latched.
- In FILL, every non-display cycle: write the latched colour at fill_cnt, then increment fill_cnt.
- The write at fill_cnt=FB_SIZE-1 returns the FSM to IDLE and raises fill_done for exactly the next cycle.
REQ-010 fill_busy SHALL be 1 exactly while the FSM is in FILL. fill_start during FILL SHALL be ignored. Host requests stall during FILL (wr_ack=0).
REQ-011 Pixel register pix SHALL load ram_rdata on the clk edge one cycle after a display slot, and hold otherwise.
REQ-012 Output pipeline: vidon, hsync_in and vsync_in SHALL each be delayed by 2 clk. hsync/vsync are the delayed syncs. Total latency is 2 clk for every output.
REQ-013 Colour outputs: when delayed vidon=1, red=pix[7:5], green=pix[4:2], blue=pix[1:0]; otherwise all colour outputs are 0.
REQ-014 Each framebuffer pixel SHALL be displayed as a 4x4 block, with column 4k..4k+3 showing the word read at column 4k.

Reset
REQ-015 While clr=0, asynchronously:
- pix=0, all delay stages=0, so hsync=vsync=0 and RGB=0.
- FSM in IDLE, fill_cnt=0, fill_busy=0, fill_done=0.
REQ-016 While clr=0, wr_ack=0 and ram_we=0.
REQ-017 A reset asserted mid-fill SHALL abort the fill with no fill_done. After release, the block is idle and accepts a new fill_start.

Verification
REQ-018 Display fetch: vidon=1, px_y=8, px_x=12 -> ram_addr=323 in that cycle; ram_rdata=8'hE3 next cycle -> red=7, green=0, blue=3 two cycles after the fetch and for the following 3 clk.
REQ-019 Contention: wr_req=1, wr_addr=100 held across a display slot -> wr_ack=0 and ram_addr=display address in the slot; wr_ack=1, ram_we=1, ram_addr=100 in the next cycle.
REQ-020 Blanking write: vidon=0, wr_req=1, wr_addr=19199 -> wr_ack=1 and ram_we=1 in the same cycle; repeat with wr_addr=19200 -> wr_ack=1, ram_we=0.
REQ-021 Fill: fill_start with fill_color=8'h1C, vidon=0 throughout -> 19200 writes at addresses 0..19199; fill_busy high for 19200 clk; one fill_done pulse; wr_req stalled for the whole fill.
REQ-022 Reset mid-fill: clr=0 at fill_cnt=5000 -> fill_busy=0 immediately; no fill_done; a new fill_start after release restarts at address 0.
REQ-023 Sync alignment: hsync_in falling edge -> hsync falls exactly 2 clk later; RGB=0 whenever vidon was 0 two clocks earlier.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// VGA framebuffer port arbiter: shares one synchronous VRAM port between
// display fetch, a hardware fill engine and host writes, and drives the
// 2-clock RGB/sync output pipeline for a 4x-upscaled 160x120 RGB332 image.
module vga_vram_arbiter #(
  parameter int unsigned FB_W    = 160,
  parameter int unsigned FB_H    = 120,
  parameter int unsigned FB_SIZE = 19200
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        vidon,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        fill_start,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);

  typedef enum logic {IDLE, FILL} fill_state_t;

  fill_state_t   state;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] fill_color_q;

  logic          disp_slot_c;
  logic [6:0]    row_c;
  logic [7:0]    col_c;
  logic [AW-1:0] disp_addr_c;
  logic          fill_gnt_c;
  logic          wr_gnt_c;
  logic          wr_in_range_c;

  logic          slot_q;
  logic          vid_d1;
  logic          hs_d1;
  logic          vs_d1;
  logic [DW-1:0] pix;
  logic [DW-1:0] pix_next_c;

  // Low row bits and the top row bit never address VRAM; the geometry
  // parameters are documentary since the row stride is fixed at 160.
  logic unused_ok;
  assign unused_ok = &{1'b0, px_y[9], px_y[1:0], FB_W[0], FB_H[0]};

  // Display slot detection and row*160+col address via shift-add
  always_comb begin
    row_c       = px_y[8:2];
    col_c       = px_x[9:2];
    disp_slot_c = vidon & (px_x[1:0] == 2'd0);
    disp_addr_c = AW'({row_c, 7'd0}) + AW'({row_c, 5'd0}) + AW'(col_c);
  end

  // Fixed-priority grants: display > fill > host; nothing granted in reset
  always_comb begin
    fill_gnt_c    = clr & (state == FILL) & ~disp_slot_c;
    wr_gnt_c      = clr & wr_req & (state == IDLE) & ~disp_slot_c;
    wr_in_range_c = (32'(wr_addr) < FB_SIZE);
  end

  // VRAM port mux and host acknowledge from the current grant
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (disp_slot_c) begin
      ram_addr = disp_addr_c;
    end else if (fill_gnt_c) begin
      ram_addr  = fill_cnt;
      ram_we    = 1'b1;
      ram_wdata = fill_color_q;
    end else if (wr_gnt_c) begin
      wr_ack    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      ram_we    = wr_in_range_c;
    end
  end

  // Fill engine: sweeps the framebuffer whenever the port is not fetching
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      fill_color_q <= '0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            state        <= FILL;
            fill_cnt     <= '0;
            fill_color_q <= fill_color;
            fill_busy    <= 1'b1;
          end
        end
        FILL: begin
          if (!disp_slot_c) begin
            if (fill_cnt == LAST_ADDR) begin
              state     <= IDLE;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel capture: read data arrives the cycle after a display slot
  always_comb begin
    pix_next_c = slot_q ? ram_rdata : pix;
  end

  // Two-stage output pipeline; stage two folds in the colour blanking
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      slot_q <= 1'b0;
      vid_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      pix    <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      red    <= 3'd0;
      green  <= 3'd0;
      blue   <= 2'd0;
    end else begin
      slot_q <= disp_slot_c;
      vid_d1 <= vidon;
      hs_d1  <= hsync_in;
      vs_d1  <= vsync_in;
      pix    <= pix_next_c;
      hsync  <= hs_d1;
      vsync  <= vs_d1;
      red    <= vid_d1 ? pix_next_c[7:5] : 3'd0;
      green  <= vid_d1 ? pix_next_c[4:2] : 3'd0;
      blue   <= vid_d1 ? pix_next_c[1:0] : 2'd0;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter with a behavioural synchronous VRAM.
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [9:0]  px_x, px_y;
  logic        vidon, hsync_in, vsync_in;
  logic        hsync, vsync;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        fill_start;
  logic [7:0]  fill_color;
  logic        fill_busy, fill_done;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:32767];
  logic [9:0] sbq [$];
  logic [7:0] exp_pix;

  always #5 clk = ~clk;

  vga_vram_arbiter dut (
    .clk(clk), .clr(clr), .px_x(px_x), .px_y(px_y), .vidon(vidon),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous VRAM: one-cycle read latency, write on we
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive video inputs for one cycle and push the output expected 2 clk later
  task automatic drive_px(input logic vid, input logic [9:0] x, input logic [9:0] y,
                          input logic hs, input logic vs);
    int a;
    vidon = vid; px_x = x; px_y = y; hsync_in = hs; vsync_in = vs;
    if (vid && (x % 4 == 0)) begin
      a = (int'(y) / 4) * 160 + int'(x) / 4;
      exp_pix = mem[a];
    end
    sbq.push_back({hs, vs, vid ? exp_pix : 8'h00});
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    clr = 1'b0;
    vidon = 1'b1; px_x = 10'd4; px_y = 10'd4; hsync_in = 1'b1; vsync_in = 1'b1;
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'h11;
    #1;
    obs = {hsync, vsync, red, green, blue, fill_busy, fill_done, wr_ack, ram_we};
    checks++;
    if (obs !== 14'd0) begin
      failures++; $display("FAIL reset_async: got %b want all zero", obs);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {hsync, vsync, red, green, blue, fill_busy, fill_done, wr_ack, ram_we};
    checks++;
    if (obs !== 14'd0) begin
      failures++; $display("FAIL reset_held: got %b want all zero", obs);
    end
    clr = 1'b1;
    vidon = 1'b0; wr_req = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    exp_pix = 8'h00;
    sbq.delete();
    @(negedge clk);
    checks++;
    if ({fill_busy, fill_done, wr_ack, ram_we} !== 4'd0) begin
      failures++;
      $display("FAIL reset_release: got %b want 0000", {fill_busy, fill_done, wr_ack, ram_we});
    end
  endtask

  task automatic test_display_fetch();
    logic [9:0] e;
    logic [9:0] x;
    mem[323] = 8'hE3;
    sbq.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      x = 10'(8 + i);
      drive_px(i < 16, x, 10'd8, 1'b1, 1'b1);
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (ram_addr !== 15'd323 || ram_we !== 1'b0) begin
          failures++;
          $display("FAIL fetch_addr: got addr=%0d we=%b want addr=323 we=0", ram_addr, ram_we);
        end
      end
      if (i >= 6 && i <= 9) begin
        checks++;
        if (red !== 3'd7 || green !== 3'd0 || blue !== 2'd3) begin
          failures++;
          $display("FAIL fetch_rgb cycle %0d: got r=%0d g=%0d b=%0d want r=7 g=0 b=3",
                   i, red, green, blue);
        end
      end
      if (sbq.size() == 3) begin
        e = sbq.pop_front();
        checks++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          failures++;
          $display("FAIL fetch_sb cycle %0d: got %h want %h", i,
                   {hsync, vsync, red, green, blue}, e);
        end
      end
    end
    sbq.delete();
  endtask

  task automatic test_sync_align();
    logic [9:0] e;
    logic vid, hs, vs;
    sbq.delete();
    for (int i = 0; i < 48; i++) begin
      tick();
      vid = ($urandom_range(3, 0) != 0);
      hs = ((i % 12) < 8);
      vs = ((i % 20) < 15);
      drive_px(vid, 10'(i), 10'd40, hs, vs);
      @(negedge clk);
      if (sbq.size() == 3) begin
        e = sbq.pop_front();
        checks++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          failures++;
          $display("FAIL sync_sb cycle %0d: got %h want %h", i,
                   {hsync, vsync, red, green, blue}, e);
        end
      end
    end
    sbq.delete();
  endtask

  task automatic test_contention();
    tick();
    drive_px(1'b1, 10'd4, 10'd0, 1'b0, 1'b0);
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h5A;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b0 || ram_addr !== 15'd1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL contention_slot: got ack=%b addr=%0d we=%b want ack=0 addr=1 we=0",
               wr_ack, ram_addr, ram_we);
    end
    tick();
    drive_px(1'b1, 10'd5, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd100 || ram_wdata !== 8'h5A) begin
      failures++;
      $display("FAIL contention_grant: got ack=%b we=%b addr=%0d data=%h want 1 1 100 5a",
               wr_ack, ram_we, ram_addr, ram_wdata);
    end
    tick();
    wr_req = 1'b0;
    drive_px(1'b0, 10'd6, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem[100] !== 8'h5A) begin
      failures++; $display("FAIL contention_mem: got %h want 5a", mem[100]);
    end
    sbq.delete();
  endtask

  task automatic test_blank_write();
    logic [7:0] orig;
    orig = 8'(19200 * 7 + 3);
    tick();
    drive_px(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    wr_req = 1'b1; wr_addr = 15'd19199; wr_data = 8'hAB;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd19199 || ram_wdata !== 8'hAB) begin
      failures++;
      $display("FAIL blank_last: got ack=%b we=%b addr=%0d data=%h want 1 1 19199 ab",
               wr_ack, ram_we, ram_addr, ram_wdata);
    end
    tick();
    wr_addr = 15'd19200; wr_data = 8'hCD;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL blank_oob: got ack=%b we=%b want ack=1 we=0", wr_ack, ram_we);
    end
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 15'd0 || ram_wdata !== 8'd0 || wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL no_grant: got we=%b addr=%0d data=%h ack=%b want all zero",
               ram_we, ram_addr, ram_wdata, wr_ack);
    end
    checks++;
    if (mem[19199] !== 8'hAB || mem[19200] !== orig) begin
      failures++;
      $display("FAIL blank_mem: got %h/%h want ab/%h", mem[19199], mem[19200], orig);
    end
    sbq.delete();
  endtask

  task automatic test_back_to_back();
    logic [22:0] wq [$];
    logic [22:0] e;
    logic slot;
    int j = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      slot = (i == 2);
      drive_px(slot, 10'd0, 10'd0, 1'b0, 1'b0);
      wr_req = 1'b1;
      wr_addr = 15'(200 + j);
      wr_data = 8'(8'h10 + j);
      if (!slot) wq.push_back({wr_addr, wr_data});
      @(negedge clk);
      checks++;
      if (wr_ack !== ~slot) begin
        failures++;
        $display("FAIL b2b_ack cycle %0d: got %b want %b", i, wr_ack, ~slot);
      end
      if (wr_ack === 1'b1 && wq.size() > 0) begin
        e = wq.pop_front();
        checks++;
        if ({ram_addr, ram_wdata} !== e) begin
          failures++;
          $display("FAIL b2b_port cycle %0d: got %h want %h", i, {ram_addr, ram_wdata}, e);
        end
      end
      if (!slot) j++;
    end
    tick();
    wr_req = 1'b0;
    drive_px(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (mem[200 + k] !== 8'(8'h10 + k)) begin
        failures++;
        $display("FAIL b2b_mem %0d: got %h want %h", 200 + k, mem[200 + k], 8'(8'h10 + k));
      end
    end
    sbq.delete();
  endtask

  task automatic test_fill();
    int busy_cnt = 0;
    int wcnt = 0;
    int werr = 0;
    int ack_in_fill = 0;
    int done_cnt = 0;
    int done_c = -1;
    int last_busy = -1;
    logic [7:0] orig;
    orig = 8'(19200 * 7 + 3);
    tick();
    drive_px(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    wr_req = 1'b0; fill_color = 8'h1C; fill_start = 1'b1;
    for (int c = 0; c < 25000; c++) begin
      tick();
      fill_start = 1'b0; fill_color = 8'hFF;
      wr_req = fill_busy; wr_addr = 15'd5; wr_data = 8'h77;
      @(negedge clk);
      if (fill_busy) begin
        busy_cnt++;
        last_busy = c;
        if (wr_ack) ack_in_fill++;
      end
      if (ram_we) begin
        if (ram_addr !== 15'(wcnt) || ram_wdata !== 8'h1C) werr++;
        wcnt++;
      end
      if (fill_done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    wr_req = 1'b0;
    checks++;
    if (busy_cnt != 19200) begin
      failures++; $display("FAIL fill_busy_len: got %0d want 19200", busy_cnt);
    end
    checks++;
    if (wcnt != 19200) begin
      failures++; $display("FAIL fill_writes: got %0d want 19200", wcnt);
    end
    checks++;
    if (werr != 0) begin
      failures++; $display("FAIL fill_addr_data: got %0d bad writes want 0", werr);
    end
    checks++;
    if (ack_in_fill != 0) begin
      failures++; $display("FAIL fill_host_stall: got %0d acks want 0", ack_in_fill);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++; $display("FAIL fill_done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (done_c != last_busy + 1) begin
      failures++; $display("FAIL fill_done_timing: got cycle %0d want %0d", done_c, last_busy + 1);
    end
    checks++;
    if (mem[0] !== 8'h1C || mem[9600] !== 8'h1C || mem[19199] !== 8'h1C) begin
      failures++;
      $display("FAIL fill_mem: got %h %h %h want 1c", mem[0], mem[9600], mem[19199]);
    end
    checks++;
    if (mem[19200] !== orig) begin
      failures++; $display("FAIL fill_overrun: got %h want %h", mem[19200], orig);
    end
    sbq.delete();
  endtask

  task automatic test_reset_mid_fill();
    int bad = 0;
    tick();
    drive_px(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    fill_color = 8'h3A; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (5000) tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 15'd5000) begin
      failures++;
      $display("FAIL midfill_pos: got we=%b addr=%0d want we=1 addr=5000", ram_we, ram_addr);
    end
    clr = 1'b0;
    wr_req = 1'b1; wr_addr = 15'd7;
    #1;
    checks++;
    if (fill_busy !== 1'b0 || ram_we !== 1'b0 || wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL midfill_abort: got busy=%b we=%b ack=%b want 0 0 0", fill_busy, ram_we, wr_ack);
    end
    repeat (3) begin
      @(negedge clk);
      if (fill_done !== 1'b0 || fill_busy !== 1'b0) bad++;
    end
    clr = 1'b1;
    wr_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fill_done !== 1'b0 || fill_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL midfill_quiet: got %0d busy/done cycles want 0", bad);
    end
    tick();
    fill_color = 8'h42; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    @(negedge clk);
    checks++;
    if (fill_busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd0 || ram_wdata !== 8'h42) begin
      failures++;
      $display("FAIL refill_start: got busy=%b we=%b addr=%0d data=%h want 1 1 0 42",
               fill_busy, ram_we, ram_addr, ram_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ram_addr !== 15'd1) begin
      failures++; $display("FAIL refill_next: got addr=%0d want 1", ram_addr);
    end
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    sbq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'(i * 7 + 3);
    clr = 1'b0;
    px_x = '0; px_y = '0; vidon = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    fill_start = 1'b0; fill_color = '0;
    exp_pix = 8'h00;
    test_reset();
    test_display_fetch();
    test_sync_align();
    test_contention();
    test_blank_write();
    test_back_to_back();
    test_fill();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
